// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Multiplexed seven-segment scan controller. It walks a one-hot active-low
//   anode strobe and a binary digit index across NUM_DIGITS digits. The scan
//   advances on the tick enable. Each digit slot is 2^BRIGHT_W ticks long,
//   and phase 0 of every slot is a forced blank. Brightness sets how many
//   phases of the slot are lit.
//
// Parameters
//   NUM_DIGITS    : digits scanned (2..16, any value in that range)
//   BRIGHT_W      : PWM resolution, slot length is 2^BRIGHT_W ticks
//   SKIP_DISABLED : 1 = scan skips digits whose digit_en bit is 0
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   tick        in   scan advance enable
//   digit_en    in   per-digit enable (0 blanks the digit)
//   brightness  in   lit phases per slot (0 = dark)
//   anodes      out  active-low anode strobes, at most one low
//   select      out  index of the current digit for the segment mux
//   frame_start out  one-cycle pulse when the scan wraps
module seg_scan_controller #(
  parameter int NUM_DIGITS    = 8,
  parameter int BRIGHT_W      = 4,
  parameter bit SKIP_DISABLED = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [$clog2(NUM_DIGITS)-1:0] select,
  output logic                          frame_start
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [SEL_W-1:0]    SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PH_LAST  = '1;

  logic [SEL_W-1:0]      sel;
  logic [BRIGHT_W-1:0]   phase;

  logic [SEL_W-1:0]      sel_p0;
  logic [BRIGHT_W-1:0]   phase_p0;
  logic [NUM_DIGITS-1:0] anodes_p0;
  logic                  frame_start_p0;
  logic                  adv_p0;

  // Modulo-N increment. Explicit wrap so indices above NUM_DIGITS-1 never
  // appear, even when NUM_DIGITS is not a power of two.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] cur);
    return (cur == SEL_LAST) ? '0 : cur + 1'b1;
  endfunction

  // First enabled digit after cur, searched circularly with cur itself as
  // the last candidate. With no digit enabled it falls back to a plain step.
  function automatic logic [SEL_W-1:0] sel_skip(input logic [SEL_W-1:0]      cur,
                                                input logic [NUM_DIGITS-1:0] en);
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] pick;
    logic             found;
    cand  = cur;
    pick  = sel_inc(cur);
    found = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cand = sel_inc(cand);
      if (!found && en[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Stage p0: next-state and output decode from the next state and the live inputs
  always_comb begin
    sel_p0   = sel;
    phase_p0 = phase;
    adv_p0   = 1'b0;
    if (tick) begin
      if (phase == PH_LAST) begin
        phase_p0 = '0;
        adv_p0   = 1'b1;
        sel_p0   = SKIP_DISABLED ? sel_skip(sel, digit_en) : sel_inc(sel);
      end else begin
        phase_p0 = phase + 1'b1;
      end
    end
    // A wrap shows up as the new index not being above the old one. This
    // also covers a lone enabled digit re-selecting itself in skip mode.
    frame_start_p0 = adv_p0 && (sel_p0 <= sel);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anodes_p0[i] = !((SEL_W'(i) == sel_p0) && digit_en[i] &&
                       (phase_p0 != '0) && (phase_p0 <= brightness));
    end
  end

  // Stage p1: state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= '0;
      phase       <= '0;
      anodes      <= '1;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_p0;
      phase       <= phase_p0;
      anodes      <= anodes_p0;
      frame_start <= frame_start_p0;
    end
  end

  assign select = sel;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller. Three instances share clk, reset, tick and
// brightness: 8 digits, 6 digits and 8 digits in skip mode, all with
// BRIGHT_W=2. The reference model counts ticks since reset. Phase and digit
// are derived arithmetically from that count, and skip mode uses a sorted
// list of enabled digits.
module tb_seg_scan_controller;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] br;
  logic [7:0] en8;
  logic [5:0] en6;
  logic [7:0] ensk;
  logic [7:0] an8;
  logic [5:0] an6;
  logic [7:0] ansk;
  logic [2:0] sel8;
  logic [2:0] sel6;
  logic [2:0] selsk;
  logic       fs8;
  logic       fs6;
  logic       fssk;

  int errors = 0;
  int checks = 0;

  // model state
  int t;
  int ssel;
  bit mfs8;
  bit mfs6;
  bit mfssk;

  seg_scan_controller #(.NUM_DIGITS(8), .BRIGHT_W(2), .SKIP_DISABLED(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .tick(tick), .digit_en(en8), .brightness(br),
    .anodes(an8), .select(sel8), .frame_start(fs8));

  seg_scan_controller #(.NUM_DIGITS(6), .BRIGHT_W(2), .SKIP_DISABLED(1'b0)) u_dut6 (
    .clk(clk), .reset(reset), .tick(tick), .digit_en(en6), .brightness(br),
    .anodes(an6), .select(sel6), .frame_start(fs6));

  seg_scan_controller #(.NUM_DIGITS(8), .BRIGHT_W(2), .SKIP_DISABLED(1'b1)) u_dutsk (
    .clk(clk), .reset(reset), .tick(tick), .digit_en(ensk), .brightness(br),
    .anodes(ansk), .select(selsk), .frame_start(fssk));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Lit iff this is the current digit, it is enabled, and the phase is in 1..br.
  function automatic int exp_an(int n, int s, int ph, int en, int b);
    int r;
    r = (1 << n) - 1;
    if ((((en >> s) & 1) == 1) && ph != 0 && ph <= b) r = r & ~(1 << s);
    return r;
  endfunction

  function automatic int skip_next(int cur, int en);
    int q[$];
    for (int i = 0; i < 8; i++) if (((en >> i) & 1) == 1) q.push_back(i);
    foreach (q[k]) if (q[k] > cur) return q[k];
    if (q.size() > 0) return q[0];
    return (cur + 1) % 8;
  endfunction

  task automatic model_reset();
    t = 0; ssel = 0; mfs8 = 0; mfs6 = 0; mfssk = 0;
  endtask

  // Apply the pending clock edge to the model, using the inputs now driven.
  task automatic model_step();
    int old;
    mfs8 = 0; mfs6 = 0; mfssk = 0;
    if (tick) begin
      t++;
      mfs8 = (t % 32) == 0;
      mfs6 = (t % 24) == 0;
      if (t % 4 == 0) begin
        old   = ssel;
        ssel  = skip_next(ssel, int'(ensk));
        mfssk = ssel <= old;
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    ph = t % 4;
    chk("an8",  32'(an8),  32'(exp_an(8, (t / 4) % 8, ph, int'(en8), int'(br))));
    chk("sel8", 32'(sel8), 32'((t / 4) % 8));
    chk("fs8",  32'(fs8),  32'(mfs8));
    chk("an6",  32'(an6),  32'(exp_an(6, (t / 4) % 6, ph, int'(en6), int'(br))));
    chk("sel6", 32'(sel6), 32'((t / 4) % 6));
    chk("fs6",  32'(fs6),  32'(mfs6));
    chk("ansk", 32'(ansk), 32'(exp_an(8, ssel, ph, int'(ensk), int'(br))));
    chk("selsk",32'(selsk),32'(ssel));
    chk("fssk", 32'(fssk), 32'(mfssk));
  endtask

  task automatic chk_reset_vals();
    chk("rst_an8",  32'(an8),  32'h0000_00FF);
    chk("rst_sel8", 32'(sel8), 32'd0);
    chk("rst_fs8",  32'(fs8),  32'd0);
    chk("rst_an6",  32'(an6),  32'h0000_003F);
    chk("rst_sel6", 32'(sel6), 32'd0);
    chk("rst_fs6",  32'(fs6),  32'd0);
    chk("rst_ansk", 32'(ansk), 32'h0000_00FF);
    chk("rst_selsk",32'(selsk),32'd0);
    chk("rst_fssk", 32'(fssk), 32'd0);
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_fixed(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_random(int n);
    for (int i = 0; i < n; i++) begin
      tick = ($urandom % 4) != 0;
      if ($urandom % 4 == 0) br = 2'($urandom);
      if ($urandom % 8 == 0) en8  = 8'($urandom);
      if ($urandom % 8 == 0) en6  = 6'($urandom);
      if ($urandom % 8 == 0) ensk = 8'($urandom);
      cycle();
    end
  endtask

  // Async reset from a negedge: values must appear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_reset_vals();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_vals();
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b1; br = 2'd3;
    en8 = 8'hFF; en6 = 6'h3F; ensk = 8'b0010_0101;
    model_reset();
    #2;
    do_reset();

    // full brightness, all enabled
    run_fixed(70);
    // partial brightness, then dark
    br = 2'd1;
    run_fixed(32);
    br = 2'd0;
    run_fixed(32);
    // everything disabled, scan keeps running
    br = 2'd3; en8 = 8'h00; en6 = 6'h00; ensk = 8'h00;
    run_fixed(40);
    // single enabled digit in skip mode
    ensk = 8'b0001_0000; en8 = 8'hFF; en6 = 6'h3F;
    run_fixed(20);
    // tick held low mid-slot, inputs changing underneath
    run_fixed(2);
    tick = 1'b0;
    run_fixed(3);
    br = 2'd2;
    run_fixed(3);
    tick = 1'b1;
    run_fixed(5);

    run_random(600);

    // mid-slot reset at sel=3, phase=2 of the 8-digit instance
    @(negedge clk);
    do_reset();
    tick = 1'b1; br = 2'd3; en8 = 8'hFF; en6 = 6'h3F; ensk = 8'b0010_0101;
    run_fixed(14);
    chk("pre_rst_sel8", 32'(sel8), 32'd3);
    do_reset();
    run_fixed(20);

    run_random(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Parametrised multiplexed seven-segment scan controller and successor to the fixed 8-digit pixel controller. It walks a one-hot active-low anode strobe and a binary digit select across NUM_DIGITS digits, advancing on an external `tick` enable. Each digit slot adds PWM brightness control with a built-in dead-time blank, per-digit enable masking, an optional mode that skips disabled digits, and a frame-start pulse. It sits between the tick generator and the segment decoder/mux, which consumes `select`.

## Interface
- `NUM_DIGITS`, default 8: number of digits scanned. Legal range 2..16; non-power-of-2 values are legal.
- `BRIGHT_W`, default 4: PWM resolution. Each digit slot lasts 2^BRIGHT_W ticks.
- `SKIP_DISABLED`, default 0: when 1, the scan skips digits whose `digit_en` bit is 0.
- `SEL_W`: localparam, equal to $clog2(NUM_DIGITS).

- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  scan advance enable, sampled each `clk` edge. It may be held high continuously.
- `digit_en`  in  NUM_DIGITS  per-digit enable; bit i=0 blanks digit i.
- `brightness`  in  BRIGHT_W  lit phases per slot. 0 means dark; all-ones is the maximum.
- `anodes`  out  NUM_DIGITS  active-low anode strobes. At most one bit is 0 at any time.
- `select`  out  SEL_W  index of the current digit, driven to the segment mux.
- `frame_start`  out  1  one-cycle pulse marking the start of a new scan frame.

## Operation
- Internal state:
  - `sel` (SEL_W bits) holds the current digit, 0..NUM_DIGITS-1.
  - `phase` (BRIGHT_W bits) holds the sub-slot count.
- Tick with phase below the last count:
  - On a `clk` edge with `tick`=1 and `phase` != 2^BRIGHT_W-1, `phase` increments.
- Tick on the last phase count:
  - On a `clk` edge with `tick`=1 and `phase` == 2^BRIGHT_W-1, `phase` goes to 0 and `sel` advances.
- No tick:
  - With `tick`=0, `sel` and `phase` hold.
- Advance, SKIP_DISABLED=0:
  - `sel` goes to (`sel`+1) mod NUM_DIGITS.
  - It wraps from NUM_DIGITS-1 to 0 for any NUM_DIGITS; indices NUM_DIGITS..2^SEL_W-1 are never reached.
- Advance, SKIP_DISABLED=1:
  - `sel` goes to the first index j, searched modulo N from `sel`+1, with `digit_en[j]`=1.
  - The search includes `sel` itself as the last candidate.
  - If no bit of `digit_en` is set, `sel` falls back to (`sel`+1) mod N.
- Anode decode:
  - `anodes[i]`=0 iff i==`sel`, `digit_en[i]`=1, `phase`!=0, and `phase` <= `brightness`. All other bits are 1.
  - Phase 0 of every slot is therefore a forced blank (anti-ghosting dead time).
  - Lit duty per slot is `brightness`/2^BRIGHT_W.
- Output source: `select` equals `sel`.
- frame_start:
  - Pulses for exactly one cycle on the edge where `sel` advances and the new `sel` <= the old `sel` (the scan wrapped).
  - In skip mode with a single enabled digit, it pulses on every slot advance.
- Input changes: `digit_en` and `brightness` are not latched per slot. A change takes effect at the next `clk` edge, including mid-slot.

## Timing
- Registered outputs: `anodes`, `select` and `frame_start` are registered, computed from next-state values and the current inputs at the same edge. Outputs therefore reflect the state they describe with zero added cycles.
- Input-to-output latency: a `digit_en` or `brightness` change with `tick`=0 appears on `anodes` one edge later.
- Reset values, asynchronous:
  - `sel`=0, `phase`=0.
  - `anodes`=all ones.
  - `select`=0.
  - `frame_start`=0.
- Reset mid-slot or mid-frame: outputs return to the reset values immediately, without waiting for a clock edge.
- First cycles after reset release: the first edge with `tick`=1 moves `phase` to 1, and digit 0 may light from that edge.
- Continuous tick: with `tick` held at 1, one slot = 2^BRIGHT_W cycles and one frame = NUM_DIGITS slots (non-skip mode).
- Boundary conditions:
  - `brightness`=0 keeps all anodes high.
  - `digit_en`=0 keeps all anodes high while the scan still runs.
  - Simultaneous events resolve in a fixed priority: `reset` > `tick`.
  - `frame_start` and the `sel` wrap occur on the same edge.

## Test plan
- Reset hold: assert `reset` with `tick`=1 -> `anodes`=all ones, `select`=0 and `frame_start`=0 throughout. These values appear asynchronously, before any clock edge.
- Full-brightness scan (N=8, BW=2, `tick`=1, `digit_en`=FF, `brightness`=3):
  - Each slot is 4 cycles: 1 blank cycle, then 3 cycles of digit i low (e.g. `anodes`=FE for digit 0).
  - `select` steps 0..7, then 0.
  - `frame_start` pulses once every 32 cycles.
- Partial brightness (`brightness`=1, BW=2): per slot `anodes` is blank, lit, blank, blank. With `brightness`=0, all anodes stay high for the whole frame.
- Non-power-of-2 depth (N=6, SEL_W=3): `select` goes 0..5, then 0, and never shows 6 or 7. `frame_start` pulses on each 5->0 transition.
- Skip mode (SKIP_DISABLED=1, N=8, `digit_en`=8'b0010_0101):
  - `select` cycles 0, 2, 5, 0 and `frame_start` pulses on each 5->0 transition.
  - With `digit_en`=0, the sequence is 0..7 and `anodes` stay all ones.
- Disruption:
  - Hold `tick`=0 mid-slot -> all outputs hold.
  - Assert `reset` at `sel`=3, `phase`=2 -> `anodes`=all ones and `select`=0 immediately.
  - After release, the scan restarts at digit 0.
